// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, reset vector and halt address.
// Imported by the state sequencer and the control unit.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_HALT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC1  = 4'd3,
        ST_EXEC2  = 4'd4
    } state_t;

    localparam logic [31:0] RESET_VECTOR      = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;

    // States in which the control unit may hold an Avalon request open.
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_EXEC1) || (s == ST_EXEC2);
    endfunction

endpackage

// File: rtl/mem_data_hold.sv
// 32-bit holding register for Avalon read data, cleared asynchronously by reset
// and loaded only when the sequencer sees a completed read.
module mem_data_hold (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);

    logic [31:0] r_q;

    // Capture register: load on completed read, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 32'h0000_0000;
        end else if (i_load) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/cpu_state_sequencer.sv
// Multi-cycle state sequencer for the Avalon-bus MIPS CPU: state, stall hold,
// read-data capture, PC commit strobe and halt. Optional counters: STATE_PERF_COUNTERS_EN.
module cpu_state_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] pc_next,
    output logic [3:0]  state,
    output logic        active,
    output logic [31:0] mem_data,
    output logic        stall,
    output logic        pc_en,
    output logic [31:0] cycle_count,
    output logic [31:0] stall_count
);

    state_t r_state;
    state_t w_state_next;
    logic   r_active;
    logic   w_stall;
    logic   w_pc_en;
    logic   w_load;

    assign w_stall = (memread | memwrite) & waitrequest & is_mem_state(r_state);
    assign w_pc_en = (r_state == ST_EXEC2) & ~w_stall;
    // A simultaneous read+write is treated as a malformed request: stall only, never capture.
    assign w_load  = memread & ~memwrite & ~waitrequest &
                     ((r_state == ST_FETCH) || (r_state == ST_EXEC1));

    // Next-state logic; any stalled state holds, unknown codes fall into HALT.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HALT:   w_state_next = ST_HALT;
            ST_FETCH:  begin
                if (!w_stall) w_state_next = ST_DECODE;
                else          w_state_next = ST_FETCH;
            end
            ST_DECODE: w_state_next = ST_EXEC1;
            ST_EXEC1:  begin
                if (!w_stall) w_state_next = ST_EXEC2;
                else          w_state_next = ST_EXEC1;
            end
            ST_EXEC2:  begin
                if (w_stall)                   w_state_next = ST_EXEC2;
                else if (pc_next == HALT_ADDR) w_state_next = ST_HALT;
                else                           w_state_next = ST_FETCH;
            end
            default:   w_state_next = ST_HALT;
        endcase
    end

    // State and active flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_FETCH;
            r_active <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_active <= r_active & (w_state_next != ST_HALT);
        end
    end

    mem_data_hold u_mem_data_hold (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_load),
        .i_d    (readdata),
        .o_q    (mem_data)
    );

`ifdef STATE_PERF_COUNTERS_EN
    logic [31:0] r_cycle_count;
    logic [31:0] r_stall_count;

    // Saturating performance counters, frozen once the CPU halts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_count <= 32'h0000_0000;
            r_stall_count <= 32'h0000_0000;
        end else begin
            if (r_active && (r_cycle_count != 32'hFFFF_FFFF)) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end else begin
                r_cycle_count <= r_cycle_count;
            end
            if (r_active && w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end else begin
                r_stall_count <= r_stall_count;
            end
        end
    end

    assign cycle_count = r_cycle_count;
    assign stall_count = r_stall_count;
`else
    assign cycle_count = 32'h0000_0000;
    assign stall_count = 32'h0000_0000;
`endif

    assign state  = r_state;
    assign active = r_active;
    assign stall  = w_stall;
    assign pc_en  = w_pc_en;

endmodule
